// File: rtl/ast_corner_pack.sv
// ast_corner_pack: turns the per-pixel {dv, q, score} stream into buffered
// {score, y, x} corner records and drains them over a valid/ready port.
// Coordinates come from dv framing. Records whose score is below score_min
// are filtered out. When the FIFO is full, new records are dropped and counted.
module ast_corner_pack #(
   parameter int unsigned W     = 8,
   parameter int unsigned CW    = 11,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                c,
   input  logic                rst_n,
   input  logic                fs,
   input  logic                dv,
   input  logic                q,
   input  logic [W-1:0]        score,
   input  logic [W-1:0]        score_min,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W+2*CW-1:0]   out_data,
   output logic [15:0]         drop_cnt,
   output logic [15:0]         corner_cnt
);

   localparam int unsigned DW   = W + 2*CW;
   localparam int unsigned CNTW = AW + 1;

   logic [CW-1:0]   x_q, x_d;
   logic [CW-1:0]   y_q, y_d;
   logic            dv_d1_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic [15:0]     corner_cnt_q, corner_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic [DW-1:0]   mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic            full;
   logic            accept;
   logic            drop;
   logic [CW-1:0]   rec_x;
   logic [CW-1:0]   rec_y;
   logic [DW-1:0]   rec;

   // Next-state for coordinates, FIFO bookkeeping, counters and registered head
   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      drop_cnt_d   = drop_cnt_q;
      corner_cnt_d = corner_cnt_q;
      out_valid_d  = 1'b0;
      out_data_d   = '0;

      // A pixel arriving with fs belongs to the new frame at the origin
      rec_x  = fs ? '0 : x_q;
      rec_y  = fs ? '0 : y_q;
      rec    = {score, rec_y, rec_x};

      push   = dv & q & (score >= score_min);
      pop    = out_valid_q & out_ready;
      full   = (count_q == CNTW'(DEPTH));
      accept = push & (~full | pop);
      drop   = push & ~accept;

      // Frame start wins over the falling-dv row advance
      if (fs) begin
         x_d = dv ? CW'(1) : '0;
         y_d = '0;
      end else if (dv) begin
         x_d = x_q + CW'(1);
      end else if (dv_d1_q) begin
         x_d = '0;
         y_d = y_q + CW'(1);
      end

      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

      case ({accept, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      if (fs) begin
         drop_cnt_d   = '0;
         corner_cnt_d = '0;
      end else begin
         if (drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
         if (accept && (corner_cnt_q != 16'hFFFF))
            corner_cnt_d = corner_cnt_q + 16'd1;
      end

      // Next head: the incoming record if the FIFO is (about to be) empty, else memory
      out_valid_d = (count_d != '0);
      if ((count_q == '0) || ((count_q == CNTW'(1)) && pop))
         out_data_d = accept ? rec : '0;
      else
         out_data_d = mem_q[rd_ptr_d];
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge c) begin
      if (!rst_n) begin
         x_q          <= '0;
         y_q          <= '0;
         dv_d1_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         drop_cnt_q   <= '0;
         corner_cnt_q <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         dv_d1_q      <= dv;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         drop_cnt_q   <= drop_cnt_d;
         corner_cnt_q <= corner_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   // Record storage; stale entries are harmless because pointers gate visibility
   always_ff @(posedge c) begin
      if (accept)
         mem_q[wr_ptr_q] <= rec;
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign drop_cnt   = drop_cnt_q;
   assign corner_cnt = corner_cnt_q;

endmodule

// File: tb/tb_ast_corner_pack.sv
// Bench for ast_corner_pack: table of per-cycle pixel vectors with expected
// record coordinates, a queue scoreboard for the output stream, and
// hand-written sequences for overflow, full push/pop and reset/fs corners.
module tb_ast_corner_pack;

   localparam int unsigned W     = 8;
   localparam int unsigned CW    = 11;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = W + 2*CW;

   logic          c = 1'b0;
   logic          rst_n = 1'b0;
   logic          fs = 1'b0;
   logic          dv = 1'b0;
   logic          q = 1'b0;
   logic [W-1:0]  score = '0;
   logic [W-1:0]  score_min = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [15:0]   drop_cnt;
   logic [15:0]   corner_cnt;

   ast_corner_pack #(.W(W), .CW(CW), .DEPTH(DEPTH), .AW(AW)) dut (
      .c          (c),
      .rst_n      (rst_n),
      .fs         (fs),
      .dv         (dv),
      .q          (q),
      .score      (score),
      .score_min  (score_min),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .drop_cnt   (drop_cnt),
      .corner_cnt (corner_cnt)
   );

   always #5 c = ~c;

   typedef struct {
      logic          fs;
      logic          dv;
      logic          q;
      logic [W-1:0]  sc;
      logic [W-1:0]  smin;
      logic          rdy;
      logic          push;
      logic [CW-1:0] ex;
      logic [CW-1:0] ey;
   } vec_t;

   vec_t          vt[$];
   logic [DW-1:0] sb[$];
   logic [15:0]   exp_corner = '0;
   logic [15:0]   exp_drop = '0;
   int            n_tests = 0;
   int            n_fail = 0;

   function automatic vec_t mk(input logic f, input logic d, input logic qq,
                               input logic [W-1:0] sc, input logic [W-1:0] smin,
                               input logic rdy, input logic push,
                               input logic [CW-1:0] ex, input logic [CW-1:0] ey);
      vec_t v;
      v.fs = f; v.dv = d; v.q = qq; v.sc = sc; v.smin = smin;
      v.rdy = rdy; v.push = push; v.ex = ex; v.ey = ey;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // One clock of stimulus: compare outputs against the scoreboard, then update it
   task automatic cycle(input vec_t v);
      logic vexp;
      @(negedge c);
      fs = v.fs; dv = v.dv; q = v.q; score = v.sc;
      score_min = v.smin; out_ready = v.rdy;
      #1;
      vexp = (sb.size() != 0);
      chk("out_valid", 64'(out_valid), 64'(vexp));
      if (vexp) chk("out_data", 64'(out_data), 64'(sb[0]));
      chk("corner_cnt", 64'(corner_cnt), 64'(exp_corner));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      if (vexp && v.rdy) void'(sb.pop_front());
      if (v.fs) begin
         exp_corner = '0;
         exp_drop   = '0;
      end
      if (v.push) begin
         if (sb.size() < DEPTH) begin
            sb.push_back({v.sc, v.ey, v.ex});
            if (!v.fs && exp_corner != 16'hFFFF) exp_corner = exp_corner + 16'd1;
         end else if (!v.fs && exp_drop != 16'hFFFF) begin
            exp_drop = exp_drop + 16'd1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge c);
      rst_n = 1'b0; fs = 1'b0; dv = 1'b0; q = 1'b0; out_ready = 1'b0;
      @(negedge c);
      rst_n = 1'b1;
      sb.delete();
      exp_corner = '0;
      exp_drop   = '0;
      #1;
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst out_data", 64'(out_data), 64'd0);
      chk("rst corner_cnt", 64'(corner_cnt), 64'd0);
      chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
   endtask

   function automatic vec_t idle(input logic rdy);
      return mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, rdy, 1'b0, '0, '0);
   endfunction

   initial begin
      do_reset();

      // Row 0: q=0101 on scores 10,20,30,40
      vt.push_back(mk(1, 0, 0, 8'd0,  8'd0, 1, 0, 11'd0, 11'd0));
      vt.push_back(mk(0, 1, 0, 8'd10, 8'd0, 1, 0, 11'd0, 11'd0));
      vt.push_back(mk(0, 1, 1, 8'd20, 8'd0, 1, 1, 11'd1, 11'd0));
      vt.push_back(mk(0, 1, 0, 8'd30, 8'd0, 1, 0, 11'd2, 11'd0));
      vt.push_back(mk(0, 1, 1, 8'd40, 8'd0, 1, 1, 11'd3, 11'd0));
      vt.push_back(idle(1));
      vt.push_back(idle(1));
      // Row 1: corner at x=5
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(0, 1, 0, 8'd1, 8'd0, 1, 0, 11'(i), 11'd1));
      vt.push_back(mk(0, 1, 1, 8'd50, 8'd0, 1, 1, 11'd5, 11'd1));
      vt.push_back(idle(1));
      vt.push_back(idle(1));
      // Row 2: corner at x=0 shows the column restarted
      vt.push_back(mk(0, 1, 1, 8'd7, 8'd0, 1, 1, 11'd0, 11'd2));
      vt.push_back(idle(1));
      // Row 3: threshold 0x30
      vt.push_back(mk(0, 1, 1, 8'h2F, 8'h30, 1, 0, 11'd0, 11'd3));
      vt.push_back(mk(0, 1, 1, 8'h30, 8'h30, 1, 1, 11'd1, 11'd3));
      vt.push_back(mk(0, 1, 1, 8'hFF, 8'h30, 1, 1, 11'd2, 11'd3));
      vt.push_back(mk(0, 0, 0, 8'h00, 8'h30, 1, 0, 11'd0, 11'd0));
      for (int i = 0; i < 4; i++) vt.push_back(idle(1));

      foreach (vt[i]) cycle(vt[i]);
      chk("frame corner_cnt", 64'(corner_cnt), 64'd6);
      chk("frame drop_cnt", 64'(drop_cnt), 64'd0);

      // Overflow: 20 corners with consumer stalled
      cycle(mk(1, 0, 0, 8'd0, 8'd0, 0, 0, 11'd0, 11'd0));
      for (int i = 0; i < 20; i++)
         cycle(mk(0, 1, 1, 8'(i + 1), 8'd0, 0, 1, 11'(i), 11'd0));
      // Full FIFO: push and pop in the same cycle
      cycle(mk(0, 1, 1, 8'hAA, 8'd0, 1, 1, 11'd20, 11'd0));
      chk("ovf drop_cnt", 64'(drop_cnt), 64'd4);
      chk("ovf corner_cnt", 64'(corner_cnt), 64'd16);
      cycle(idle(1));
      chk("full pushpop drop_cnt", 64'(drop_cnt), 64'd4);
      chk("full pushpop corner_cnt", 64'(corner_cnt), 64'd17);
      for (int i = 0; i < 18; i++) cycle(idle(1));
      chk("drained out_valid", 64'(out_valid), 64'd0);

      // Reset with records queued and consumer stalled
      cycle(mk(1, 0, 0, 8'd0, 8'd0, 0, 0, 11'd0, 11'd0));
      for (int i = 0; i < 5; i++)
         cycle(mk(0, 1, 1, 8'(8'h60 + i), 8'd0, 0, 1, 11'(i), 11'd0));
      do_reset();
      cycle(idle(0));

      // fs mid-row: older records still drain, new pixel restarts at the origin
      cycle(mk(0, 1, 1, 8'h11, 8'd0, 0, 1, 11'd0, 11'd0));
      cycle(mk(0, 1, 1, 8'h22, 8'd0, 0, 1, 11'd1, 11'd0));
      cycle(mk(1, 1, 1, 8'h33, 8'd0, 0, 1, 11'd0, 11'd0));
      cycle(mk(0, 1, 1, 8'h44, 8'd0, 0, 1, 11'd1, 11'd0));
      cycle(idle(1));
      chk("post-fs corner_cnt", 64'(corner_cnt), 64'd1);
      for (int i = 0; i < 6; i++) cycle(idle(1));
      chk("final out_valid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
